// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one valid/ready producer side and N_OUT
// independent valid/ready consumer channels packed into flat vectors.
interface demux_stream_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-N_OUT stream demultiplexer with broadcast, a one-entry
// register per output channel, and a saturating counter of dropped words.
module demux_stream #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_stream_if.slave    bus,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] drop_count
);

    logic [N_OUT-1:0]        valid_r;
    logic [N_OUT*DATA_W-1:0] data_r;
    logic                    drop_r;
    logic [CNT_W-1:0]        count_r;

    logic [N_OUT-1:0]        free_s;
    logic [N_OUT-1:0]        hot_s;
    logic [N_OUT-1:0]        load_s;
    logic                    sel_ok_s;
    logic                    ready_s;
    logic                    accept_s;
    logic                    drop_s;

    // Select decode, readiness and per-channel load enables; a channel
    // draining this cycle counts as free so each channel sustains 1 word/cycle.
    always_comb begin
        free_s = {N_OUT{1'b0}};
        hot_s  = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            free_s[i] = ~valid_r[i] | bus.out_ready[i];
            hot_s[i]  = (bus.in_sel == SEL_W'(i));
        end
        sel_ok_s = |hot_s;
        ready_s  = 1'b0;
        if (bus.in_bcast) begin
            ready_s = &free_s;
        end else if (sel_ok_s) begin
            ready_s = |(hot_s & free_s);
        end else begin
            ready_s = 1'b1;
        end
        accept_s = bus.in_valid & ready_s;
        drop_s   = accept_s & ~bus.in_bcast & ~sel_ok_s;
        if (bus.in_bcast) begin
            load_s = {N_OUT{accept_s}};
        end else begin
            load_s = {N_OUT{accept_s}} & hot_s;
        end
    end

    // Output channel registers: a load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {N_OUT{1'b0}};
            data_r  <= {(N_OUT*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (load_s[i]) begin
                    valid_r[i]                  <= 1'b1;
                    data_r[i*DATA_W +: DATA_W]  <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    valid_r[i]                  <= 1'b0;
                end
            end
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            drop_r <= drop_s;
            if (drop_s && (count_r != {CNT_W{1'b1}})) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = valid_r;
    assign bus.out_data  = data_r;
    assign drop_pulse    = drop_r;
    assign drop_count    = count_r;

endmodule
